force_release_ctrl: RTL and testbench
=====================================

# force_release_ctrl

Synthesizable hardware counterpart of simulator force/release: a single W-bit register whose value is normally driven by a functional path, but which a debug/test master can override with a force command and later hand back with a release command. Sits between a functional datapath register and the debug register bank, so test firmware can pin internal values. Emits an event stream so a monitor block can log every change.

## Interface
- W, 5, data width
- NET_MODE, 0, 1: net semantics, so on release q reverts to the live driver value; 0: variable semantics, so q keeps the forced value until the next functional write
- RST_VAL, 0, reset value of q
- CW, 8, force-duration counter width (used only with OVR_TIMEOUT_EN)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- func_vld  in  1  functional write strobe; in NET_MODE, ignored and func_data is treated as continuously driven
- func_data  in  W  functional value
- frc_req  in  1  force request, single-cycle strobe
- frc_data  in  W  value to force
- frc_dur  in  CW  force duration in cycles, 0 = indefinite (present only with OVR_TIMEOUT_EN)
- frc_ack  out  1  one-cycle pulse acknowledging a force
- rel_req  in  1  release request, single-cycle strobe
- rel_ack  out  1  one-cycle pulse acknowledging a release
- q  out  W  registered output value
- forced  out  1  high while the override is active
- evt_vld  out  1  one-cycle pulse when q changes or a force/release happens
- evt_code  out  2  event code: 0 FUNC, 1 FORCE, 2 RELEASE, 3 TIMEOUT

## Operation
- States:
  - FUNC: q follows the functional path.
  - FORCED: q = forced value.
  - HELD: variable mode only; after release, q keeps the forced value.
- FUNC:
  - Variable mode: func_vld loads func_data into q.
  - NET_MODE: q loads func_data every cycle.
  - On frc_req: q takes frc_data and the block goes to FORCED.
- FORCED:
  - Functional writes do not change q.
  - NET_MODE: a shadow register tracks func_data every cycle.
  - frc_req re-forces with the new frc_data and restarts the timer.
  - On rel_req, NET_MODE: q takes the shadow value and the block goes to FUNC.
  - On rel_req, variable mode: q is unchanged and the block goes to HELD.
- HELD: the next func_vld loads q and returns the block to FUNC. frc_req goes to FORCED.
- Same-cycle frc_req and rel_req: force wins. Release is dropped and rel_ack stays low.
- rel_req while not FORCED: no state change. rel_ack still pulses (release of an unforced value is a legal no-op). No event is emitted.
- func_vld together with rel_req in variable mode: the release is taken, then func_data is loaded in the same cycle, ending in FUNC. Emit RELEASE only.
- evt_vld fires:
  - on every FORCE, RELEASE and TIMEOUT;
  - on FUNC only when q actually changes value.
- Reset (all synchronous):
  - q = RST_VAL; state FUNC; forced = 0.
  - frc_ack, rel_ack and evt_vld = 0; evt_code = 0.
  - Shadow = RST_VAL; timer = 0.
- Reset mid-force: the override is dropped unconditionally and no event is emitted.

## Timing
- q, forced, acks and evt_* are all registered: 1-cycle latency from the request edge.
- frc_req sampled at edge n: q = frc_data, forced = 1, frc_ack = 1 and evt FORCE are all visible after edge n.
- rel_req at edge n: forced = 0 and rel_ack = 1 after edge n. In NET_MODE, q = func_data sampled at edge n.
- The requester must not rely on a request being held; requests are edge-sampled strobes.
- Back-to-back requests every cycle are accepted.

## Configuration
- OVR_TIMEOUT_EN defined:
  - frc_dur port is present; the timer loads frc_dur on each accepted force.
  - The timer decrements each FORCED cycle; when it reaches 0 from 1, an auto-release happens at that edge, following the release rules.
  - Auto-release signals evt_code TIMEOUT and gives no rel_ack.
  - frc_dur = 0 means no timeout.
- OVR_TIMEOUT_EN undefined: no frc_dur port and no timer logic; forces last until rel_req.

## Structure
- Package force_release_pkg:
  - state enum: FUNC, FORCED, HELD;
  - evt_code enum: EVT_FUNC, EVT_FORCE, EVT_RELEASE, EVT_TIMEOUT.
- Sub-module force_timer: a CW-bit loadable down-counter with an expire pulse. It is instantiated only under OVR_TIMEOUT_EN.

## Test plan
- Variable mode, W=5: func write 6, then force 10 at t0, then rel_req 1 cycle later.
  - Required: q=6, then 10 with FORCE evt, then q stays 10 in HELD.
  - A later func write 15 gives q=15 and a FUNC evt.
- NET_MODE with func_data held at 5: force 11, hold 5 cycles, release.
  - Required: q=11 while forced, then q=5 the cycle after release, rel_ack=1.
- Same-cycle frc_req (data 3) and rel_req while FORCED at 10: q=3, forced stays 1, frc_ack=1, rel_ack=0.
- rel_req in FUNC with q=6: rel_ack=1, no evt, q=6.
- OVR_TIMEOUT_EN, frc_dur=4, force 20: q=20 for 4 cycles, then TIMEOUT evt and forced=0.
  - With frc_dur=0, no timeout occurs over 100 cycles.
- Assert rst during FORCED at q=10: the next cycle has q=RST_VAL, forced=0, state FUNC, and no evt.

Source files
------------

// File: rtl/force_release_pkg.sv
// force_release_pkg: state and event encodings shared by force_release_ctrl.
package force_release_pkg;
  typedef enum logic [1:0] {FUNC, FORCED, HELD} state_e;
  typedef enum logic [1:0] {EVT_FUNC, EVT_FORCE, EVT_RELEASE, EVT_TIMEOUT} evt_e;
endpackage

// File: rtl/force_release_ctrl_timer.sv
// force_timer: loadable down-counter; expire marks the 1->0 step while enabled.
module force_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          expire
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  assign expire = en && !load && cnt_q == CW'(1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/force_release_ctrl.sv
// force_release_ctrl: W-bit register with debug force/release override and change events.
// Optional OVR_TIMEOUT_EN adds frc_dur and an auto-release timer.
module force_release_ctrl
  import force_release_pkg::*;
#(
  parameter int             W        = 5,
  parameter int             NET_MODE = 0,
  parameter logic [W-1:0]   RST_VAL  = '0
`ifdef OVR_TIMEOUT_EN
  , parameter int           CW       = 8
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          func_vld,
  input  logic [W-1:0]  func_data,
  input  logic          frc_req,
  input  logic [W-1:0]  frc_data,
`ifdef OVR_TIMEOUT_EN
  input  logic [CW-1:0] frc_dur,
`endif
  output logic          frc_ack,
  input  logic          rel_req,
  output logic          rel_ack,
  output logic [W-1:0]  q,
  output logic          forced,
  output logic          evt_vld,
  output logic [1:0]    evt_code
);
  state_e       st_q, st_d;
  evt_e         evt_code_q, evt_code_d;
  logic [W-1:0] q_q, q_d;
  logic         evt_vld_q, evt_vld_d, frc_ack_q, frc_ack_d, rel_ack_q, rel_ack_d;
  logic         tmo, net, fwr, rel_take;
`ifdef OVR_TIMEOUT_EN
  force_timer #(.CW(CW)) u_timer (
    .clk(clk), .rst(rst), .load(frc_req), .load_val(frc_dur),
    .en(st_q == FORCED), .expire(tmo)
  );
`else
  assign tmo = 1'b0;
`endif
  assign net      = NET_MODE != 0;
  assign fwr      = net || func_vld;
  assign rel_take = !frc_req && st_q == FORCED && (rel_req || tmo);
  // In net mode the live func_data is the shadow: release restores the value sampled at that edge.
  always_comb begin
    st_d       = st_q;
    q_d        = q_q;
    evt_vld_d  = 1'b0;
    evt_code_d = EVT_FUNC;
    frc_ack_d  = frc_req;
    rel_ack_d  = rel_req && !frc_req;
    if (frc_req) begin
      q_d        = frc_data;
      st_d       = FORCED;
      evt_vld_d  = 1'b1;
      evt_code_d = EVT_FORCE;
    end else if (rel_take) begin
      st_d       = fwr ? FUNC : HELD;
      q_d        = fwr ? func_data : q_q;
      evt_vld_d  = 1'b1;
      evt_code_d = rel_req ? EVT_RELEASE : EVT_TIMEOUT;
    end else if (st_q != FORCED && fwr) begin
      q_d       = func_data;
      st_d      = FUNC;
      evt_vld_d = func_data != q_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= FUNC;
      q_q        <= RST_VAL;
      evt_vld_q  <= 1'b0;
      evt_code_q <= EVT_FUNC;
      frc_ack_q  <= 1'b0;
      rel_ack_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      q_q        <= q_d;
      evt_vld_q  <= evt_vld_d;
      evt_code_q <= evt_code_d;
      frc_ack_q  <= frc_ack_d;
      rel_ack_q  <= rel_ack_d;
    end
  end
  assign q        = q_q;
  assign forced   = st_q == FORCED;
  assign evt_vld  = evt_vld_q;
  assign evt_code = evt_code_q;
  assign frc_ack  = frc_ack_q;
  assign rel_ack  = rel_ack_q;
endmodule

// File: tb/tb_force_release_ctrl.sv
// tb_force_release_ctrl: directed checks of variable-mode and net-mode force/release.
module tb_force_release_ctrl;
  import force_release_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic       v_func_vld = 0, v_frc_req = 0, v_rel_req = 0;
  logic [4:0] v_func_data = 0, v_frc_data = 0;
  logic       v_frc_ack, v_rel_ack, v_forced, v_evt_vld;
  logic [4:0] v_q;
  logic [1:0] v_evt_code;
  logic       n_func_vld = 0, n_frc_req = 0, n_rel_req = 0;
  logic [4:0] n_func_data = 5, n_frc_data = 0;
  logic       n_frc_ack, n_rel_ack, n_forced, n_evt_vld;
  logic [4:0] n_q;
  logic [1:0] n_evt_code;
`ifdef OVR_TIMEOUT_EN
  logic [7:0] v_frc_dur = 0, n_frc_dur = 0;
`endif
  int total = 0, bad = 0;
  force_release_ctrl #(.W(5), .NET_MODE(0), .RST_VAL(5'd0)) u_var (
    .clk(clk), .rst(rst), .func_vld(v_func_vld), .func_data(v_func_data),
    .frc_req(v_frc_req), .frc_data(v_frc_data),
`ifdef OVR_TIMEOUT_EN
    .frc_dur(v_frc_dur),
`endif
    .frc_ack(v_frc_ack), .rel_req(v_rel_req), .rel_ack(v_rel_ack), .q(v_q),
    .forced(v_forced), .evt_vld(v_evt_vld), .evt_code(v_evt_code)
  );
  force_release_ctrl #(.W(5), .NET_MODE(1), .RST_VAL(5'd0)) u_net (
    .clk(clk), .rst(rst), .func_vld(n_func_vld), .func_data(n_func_data),
    .frc_req(n_frc_req), .frc_data(n_frc_data),
`ifdef OVR_TIMEOUT_EN
    .frc_dur(n_frc_dur),
`endif
    .frc_ack(n_frc_ack), .rel_req(n_rel_req), .rel_ack(n_rel_ack), .q(n_q),
    .forced(n_forced), .evt_vld(n_evt_vld), .evt_code(n_evt_code)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_q", 32'(v_q), 0);
    chk("rst_forced", 32'(v_forced), 0);
    chk("rst_evt", 32'(v_evt_vld), 0);
    chk("rst_acks", 32'({v_frc_ack, v_rel_ack}), 0);
    chk("rst_code", 32'(v_evt_code), 0);
    v_func_vld = 1; v_func_data = 6; tick();
    chk("func6_q", 32'(v_q), 6);
    chk("func6_evt", 32'({v_evt_vld, v_evt_code}), {1'b1, 2'd0});
    v_func_vld = 0; v_frc_req = 1; v_frc_data = 10; tick();
    chk("frc10_q", 32'(v_q), 10);
    chk("frc10_flags", 32'({v_forced, v_frc_ack, v_evt_vld, v_evt_code}), {3'b111, 2'd1});
    v_frc_req = 0; v_rel_req = 1; tick();
    chk("rel_q", 32'(v_q), 10);
    chk("rel_flags", 32'({v_forced, v_rel_ack, v_evt_vld, v_evt_code}), {3'b011, 2'd2});
    chk("rel_state", 32'(u_var.st_q), 32'(HELD));
    v_rel_req = 0; tick();
    chk("held_q", 32'(v_q), 10);
    chk("held_noevt", 32'(v_evt_vld), 0);
    v_func_vld = 1; v_func_data = 15; tick();
    chk("func15_q", 32'(v_q), 15);
    chk("func15_evt", 32'({v_evt_vld, v_evt_code}), {1'b1, 2'd0});
    chk("func15_state", 32'(u_var.st_q), 32'(FUNC));
    tick();
    chk("func_same_noevt", 32'(v_evt_vld), 0);
    v_func_data = 6; tick();
    v_func_vld = 0; v_rel_req = 1; tick();
    chk("relfunc_q", 32'(v_q), 6);
    chk("relfunc_flags", 32'({v_forced, v_rel_ack, v_evt_vld}), 3'b010);
    v_rel_req = 0; v_frc_req = 1; v_frc_data = 10; tick();
    v_frc_data = 3; v_rel_req = 1; tick();
    chk("both_q", 32'(v_q), 3);
    chk("both_flags", 32'({v_forced, v_frc_ack, v_rel_ack, v_evt_code}), {3'b110, 2'd1});
    v_frc_req = 0; v_rel_req = 0; v_func_vld = 1; v_func_data = 7; tick();
    chk("forced_func_ignored", 32'(v_q), 3);
    v_func_data = 9; v_rel_req = 1; tick();
    chk("relwr_q", 32'(v_q), 9);
    chk("relwr_flags", 32'({v_forced, v_rel_ack, v_evt_vld, v_evt_code}), {3'b011, 2'd2});
    chk("relwr_state", 32'(u_var.st_q), 32'(FUNC));
    v_rel_req = 0; v_func_vld = 0; v_frc_req = 1; v_frc_data = 10; tick();
    v_frc_req = 0; rst = 1; tick();
    rst = 0;
    chk("midrst_q", 32'(v_q), 0);
    chk("midrst_flags", 32'({v_forced, v_evt_vld, v_frc_ack}), 0);
    chk("midrst_state", 32'(u_var.st_q), 32'(FUNC));
    tick();
    chk("net_track", 32'(n_q), 5);
    n_frc_req = 1; n_frc_data = 11; tick();
    n_frc_req = 0;
    chk("net_frc_q", 32'(n_q), 11);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("net_hold_q", 32'({n_forced, n_q}), {1'b1, 5'd11});
    end
    n_rel_req = 1; tick();
    n_rel_req = 0;
    chk("net_rel_q", 32'(n_q), 5);
    chk("net_rel_flags", 32'({n_forced, n_rel_ack, n_evt_vld, n_evt_code}), {3'b011, 2'd2});
    n_frc_req = 1; n_frc_data = 2; tick();
    n_frc_req = 0; n_func_data = 12; tick();
    chk("net_forced_live", 32'(n_q), 2);
    n_func_data = 13; n_rel_req = 1; tick();
    n_rel_req = 0;
    chk("net_rel_live", 32'(n_q), 13);
`ifdef OVR_TIMEOUT_EN
    v_frc_req = 1; v_frc_data = 20; v_frc_dur = 4; tick();
    v_frc_req = 0;
    chk("tmo_start", 32'({v_forced, v_q}), {1'b1, 5'd20});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_hold", 32'({v_forced, v_q}), {1'b1, 5'd20});
    end
    tick();
    chk("tmo_fire", 32'({v_forced, v_rel_ack, v_evt_vld, v_evt_code}), {3'b001, 2'd3});
    chk("tmo_q", 32'(v_q), 20);
    v_frc_req = 1; v_frc_data = 21; v_frc_dur = 0; tick();
    v_frc_req = 0;
    for (int i = 0; i < 100; i++) tick();
    chk("tmo_indef", 32'({v_forced, v_q}), {1'b1, 5'd21});
    v_rel_req = 1; tick();
    v_rel_req = 0;
    chk("tmo_indef_rel", 32'({v_forced, v_rel_ack}), 2'b01);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
